// File: rtl/sigma_delta_dac.sv
// rtl/sigma_delta_dac.sv - first-order sigma-delta PDM modulator with sample pacing and underrun flag
module sigma_delta_dac #(
    parameter int DATA_WIDTH = 16,
    parameter int OSR_DIV    = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic                  sample_req,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] sample_data,
    input  logic                  clr_underrun,
    output logic                  dac_out,
    output logic                  underrun
);

    // A two-cycle period still needs one counter bit.
    localparam int CNT_W = (OSR_DIV > 2) ? $clog2(OSR_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OSR_DIV - 1);
    // Mid-scale of the offset-binary range: an idle output with 50% density.
    localparam logic [DATA_WIDTH-1:0] MID_SCALE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [CNT_W-1:0]      div_cnt;
    logic                  pending;
    logic [DATA_WIDTH-1:0] hold;
    logic [DATA_WIDTH-1:0] acc;

    logic                  req_fire;
    logic                  accept;
    logic                  starve;
    logic [DATA_WIDTH:0]   sum;

    // A request is issued on the edge where the enabled divider sits at zero.
    assign req_fire = en && (div_cnt == '0);

    // Only a sample answering an outstanding request is taken.
    assign accept = en && sample_valid && pending;

    // A new request while the previous one is still unanswered means upstream
    // missed a whole period; a sample arriving on that same edge still counts.
    assign starve = req_fire && pending && !sample_valid;

    // The carry out of the accumulator is the PDM bit.
    assign sum = {1'b0, acc} + {1'b0, hold};

    // Divider and registered one-cycle request pulse; disable restarts the cadence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt    <= '0;
            sample_req <= 1'b0;
        end else if (!en) begin
            div_cnt    <= '0;
            sample_req <= 1'b0;
        end else begin
            sample_req <= req_fire;
            if (div_cnt == CNT_MAX) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + CNT_W'(1);
            end
        end
    end

    // Request/accept handshake; hold keeps the last good sample across underruns and disable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
            hold    <= MID_SCALE;
        end else if (!en) begin
            pending <= 1'b0;
        end else begin
            if (accept) begin
                hold <= sample_data;
            end
            // A fresh request outranks the clear from a coincident accept.
            if (req_fire) begin
                pending <= 1'b1;
            end else if (accept) begin
                pending <= 1'b0;
            end
        end
    end

    // Sticky underrun flag; a new underrun wins over a coincident clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun <= 1'b0;
        end else if (starve) begin
            underrun <= 1'b1;
        end else if (clr_underrun) begin
            underrun <= 1'b0;
        end
    end

    // First-order error-feedback accumulator producing the registered bitstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            dac_out <= 1'b0;
        end else if (!en) begin
            acc     <= '0;
            dac_out <= 1'b0;
        end else begin
            acc     <= sum[DATA_WIDTH-1:0];
            dac_out <= sum[DATA_WIDTH];
        end
    end

endmodule
